// File: rtl/hazard_scoreboard_if.sv
// Decode/writeback/flush bundle between the pipeline and hazard_scoreboard.
// The master side is the pipeline; the slave side is the scoreboard.
interface hazard_scoreboard_if;
    logic        de_v;
    logic [4:0]  de_rs1;
    logic [4:0]  de_rs2;
    logic        de_use_rs1;
    logic        de_use_rs2;
    logic [4:0]  de_rd;
    logic        de_we;
    logic        wb_v;
    logic [4:0]  wb_rd;
    logic        wb_kill;
    logic        flush;
    logic        stall;
    logic        issue;
    logic [31:0] busy_vec;
    logic [2:0]  inflight;
    logic        draining;
    logic        sb_err;

    modport master (
        output de_v, de_rs1, de_rs2, de_use_rs1, de_use_rs2, de_rd, de_we,
        output wb_v, wb_rd, wb_kill, flush,
        input  stall, issue, busy_vec, inflight, draining, sb_err
    );

    modport slave (
        input  de_v, de_rs1, de_rs2, de_use_rs1, de_use_rs2, de_rd, de_we,
        input  wb_v, wb_rd, wb_kill, flush,
        output stall, issue, busy_vec, inflight, draining, sb_err
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Register-write scoreboard: per-register pending counts, in-flight limit and flush drain FSM.
// Define SB_BYPASS_EN to let a same-cycle WB_V retire clear a single-pending source hazard.
module hazard_scoreboard #(
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    hazard_scoreboard_if.slave   sb
);

    typedef enum logic {ST_RUN, ST_DRAIN} state_t;

    state_t      r_state;
    logic        r_draining;
    logic        r_sb_err;
    logic [2:0]  r_inflight;
    logic [1:0]  r_cnt [32];
    logic [31:0] r_busy_vec;

    logic        w_haz_rs1;
    logic        w_haz_rs2;
    logic        w_sat;
    logic        w_full;
    logic        w_stall;
    logic        w_issue;
    logic [31:0] w_inc_vec;
    logic [31:0] w_dec_vec;
    logic [1:0]  w_cnt_nxt [32];
    logic [31:0] w_busy_nxt;
    logic        w_cnt_err;
    logic [3:0]  w_inflight_up;
    logic [3:0]  w_inflight_dn;
    logic [2:0]  w_inflight_nxt;
    logic        w_inflight_err;

    always_comb begin
        w_haz_rs1 = sb.de_use_rs1 && (sb.de_rs1 != 5'd0) && (r_cnt[sb.de_rs1] != 2'd0);
        w_haz_rs2 = sb.de_use_rs2 && (sb.de_rs2 != 5'd0) && (r_cnt[sb.de_rs2] != 2'd0);
`ifdef SB_BYPASS_EN
        // The last pending write to a source retiring this cycle forwards its value.
        if (sb.wb_v && (sb.wb_rd == sb.de_rs1) && (r_cnt[sb.de_rs1] == 2'd1)) w_haz_rs1 = 1'b0;
        if (sb.wb_v && (sb.wb_rd == sb.de_rs2) && (r_cnt[sb.de_rs2] == 2'd1)) w_haz_rs2 = 1'b0;
`endif
    end

    assign w_sat   = sb.de_we && (sb.de_rd != 5'd0) && (r_cnt[sb.de_rd] == 2'd3);
    assign w_full  = (r_inflight == 3'(MAX_INFLIGHT));
    // Gated by reset so decode sees neither stall nor issue while the block is held in reset.
    assign w_stall = i_rst_n && sb.de_v &&
                     (w_haz_rs1 || w_haz_rs2 || w_sat || w_full ||
                      (r_state == ST_DRAIN) || sb.flush);
    assign w_issue = i_rst_n && sb.de_v && !w_stall;

    assign w_inc_vec = (w_issue && sb.de_we && (sb.de_rd != 5'd0)) ? (32'd1 << sb.de_rd) : 32'd0;
    assign w_dec_vec = (sb.wb_v && (sb.wb_rd != 5'd0)) ? (32'd1 << sb.wb_rd) : 32'd0;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_cnt_err     = 1'b0;
        w_busy_nxt    = 32'd0;
        w_cnt_nxt[0]  = 2'd0;
        for (int i = 1; i < 32; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (w_inc_vec[i] && !w_dec_vec[i]) begin
                w_cnt_nxt[i] = r_cnt[i] + 2'd1;
            end else if (w_dec_vec[i] && !w_inc_vec[i]) begin
                if (r_cnt[i] == 2'd0) w_cnt_err    = 1'b1;
                else                  w_cnt_nxt[i] = r_cnt[i] - 2'd1;
            end
            w_busy_nxt[i] = (w_cnt_nxt[i] != 2'd0);
        end
    end

    always_comb begin
        w_inflight_up  = {1'b0, r_inflight} + {3'd0, w_issue};
        w_inflight_dn  = {3'd0, sb.wb_v} + {3'd0, sb.wb_kill};
        w_inflight_err = 1'b0;
        w_inflight_nxt = 3'(w_inflight_up - w_inflight_dn);
        // Retires beyond the outstanding count are dropped rather than wrapping.
        if (w_inflight_up < w_inflight_dn) begin
            w_inflight_err = 1'b1;
            w_inflight_nxt = 3'd0;
        end
    end

    // NOTE: the count array is reset because a stale count would raise a false hazard.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 32; i++) r_cnt[i] <= 2'd0;
            r_busy_vec <= 32'd0;
            r_inflight <= 3'd0;
            r_sb_err   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            for (int i = 0; i < 32; i++) r_cnt[i] <= w_cnt_nxt[i];
            r_busy_vec <= w_busy_nxt;
            r_inflight <= w_inflight_nxt;
            if (w_cnt_err || w_inflight_err) r_sb_err <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_RUN;
            r_draining <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (sb.flush) begin
                        r_state    <= ST_DRAIN;
                        r_draining <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (!sb.flush && (r_inflight == 3'd0)) begin
                        r_state    <= ST_RUN;
                        r_draining <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_draining <= 1'b0;
                end
            endcase
        end
    end

    assign sb.stall    = w_stall;
    assign sb.issue    = w_issue;
    assign sb.busy_vec = r_busy_vec;
    assign sb.inflight = r_inflight;
    assign sb.draining = r_draining;
    assign sb.sb_err   = r_sb_err;

endmodule
